// File: rtl/fifo_pack_flush.sv
// fifo_pack_flush: narrow-to-wide packing FIFO with a flush handshake.
// IN_W-bit write beats are packed lane by lane into PACK-lane words and queued
// (DEPTH_WORDS deep). A flush seals any partial word by filling its unused
// lanes with PAD_VAL, drains the queue, then pulses flush_done_o for one cycle.
// Optional feature macro FIFO_PACK_OCC_EN adds occupancy ports words_o and
// lanes_o.
module fifo_pack_flush #(
    parameter int unsigned     IN_W        = 4,
    parameter int unsigned     PACK        = 8,
    parameter int unsigned     DEPTH_WORDS = 4,
    parameter logic [IN_W-1:0] PAD_VAL     = 4'hC
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_valid_i,
    output logic                           wr_ready_o,
    input  logic [IN_W-1:0]                wr_data_i,
    output logic                           rd_valid_o,
    input  logic                           rd_ready_i,
    output logic [IN_W*PACK-1:0]           rd_data_o,
    output logic [$clog2(PACK+1)-1:0]      rd_fill_o,
    input  logic                           flush_req_i,
    output logic                           flush_done_o,
    output logic                           full_o,
    output logic                           empty_o
`ifdef FIFO_PACK_OCC_EN
    ,
    output logic [$clog2(DEPTH_WORDS+1)-1:0] words_o,
    output logic [$clog2(PACK)-1:0]          lanes_o
`endif
);

    localparam int unsigned LaneW = $clog2(PACK);
    localparam int unsigned AddrW = $clog2(DEPTH_WORDS);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned FillW = $clog2(PACK + 1);
    localparam int unsigned WordW = IN_W * PACK;

    typedef enum logic [1:0] {StIdle, StSeal, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [LaneW-1:0] lane_q, lane_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;

    logic [IN_W-1:0]  lanes_q  [PACK];
    logic [WordW-1:0] mem_data [DEPTH_WORDS];
    logic [FillW-1:0] mem_fill [DEPTH_WORDS];

    logic [PtrW-1:0]  count;
    logic             is_full;
    logic             is_empty;
    logic             lane_last;
    logic             seal_en;
    logic             wr_fire;
    logic             pop;
    logic             commit;
    logic [WordW-1:0] commit_word;
    logic [FillW-1:0] commit_fill;

    // Queue status derived from the wrap-extended pointer difference.
    always_comb begin
        count     = wr_ptr_q - rd_ptr_q;
        is_full   = (count == PtrW'(DEPTH_WORDS));
        is_empty  = (count == '0);
        lane_last = (lane_q == LaneW'(PACK - 1));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; SEAL waits while a partial word has no free slot.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (flush_req_i) state_d = StSeal;
            StSeal:  if ((lane_q == '0) || !is_full) state_d = StDrain;
            StDrain: if (is_empty) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: write acceptance, seal commit enable and done pulse.
    always_comb begin
        wr_ready_o   = 1'b0;
        flush_done_o = 1'b0;
        seal_en      = 1'b0;
        unique case (state_q)
            StIdle:  wr_ready_o = !lane_last || !is_full;
            StSeal:  seal_en = (lane_q != '0) && !is_full;
            StDone:  flush_done_o = 1'b1;
            default: ;
        endcase
    end

    // Commit word: held lanes below the lane index, then either the live beat
    // (completing word) or PAD_VAL (sealed partial word).
    always_comb begin
        wr_fire     = wr_valid_i && wr_ready_o;
        pop         = !is_empty && rd_ready_i;
        commit      = (wr_fire && lane_last) || seal_en;
        commit_fill = seal_en ? FillW'(lane_q) : FillW'(PACK);
        commit_word = '0;
        for (int k = 0; k < PACK; k++) begin
            if (LaneW'(k) < lane_q) begin
                commit_word[k*IN_W +: IN_W] = lanes_q[k];
            end else if (seal_en) begin
                commit_word[k*IN_W +: IN_W] = PAD_VAL;
            end else begin
                commit_word[k*IN_W +: IN_W] = wr_data_i;
            end
        end
    end

    // Next lane index and pointers; pop and commit in one cycle both apply.
    always_comb begin
        lane_d = lane_q;
        if (wr_fire) begin
            lane_d = lane_last ? '0 : lane_q + LaneW'(1);
        end else if (seal_en) begin
            lane_d = '0;
        end
        wr_ptr_d = commit ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    end

    // Control registers: lane index and queue pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            lane_q   <= lane_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Lane and word storage; validity comes from the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            lanes_q[lane_q] <= wr_data_i;
        end
        if (commit) begin
            mem_data[wr_ptr_q[AddrW-1:0]] <= commit_word;
            mem_fill[wr_ptr_q[AddrW-1:0]] <= commit_fill;
        end
    end

    // Read port and status outputs; head is forced to zero when empty.
    always_comb begin
        rd_valid_o = !is_empty;
        rd_data_o  = is_empty ? '0 : mem_data[rd_ptr_q[AddrW-1:0]];
        rd_fill_o  = is_empty ? '0 : mem_fill[rd_ptr_q[AddrW-1:0]];
        full_o     = is_full;
        empty_o    = is_empty && (lane_q == '0);
    end

`ifdef FIFO_PACK_OCC_EN
    localparam int unsigned CntW = $clog2(DEPTH_WORDS + 1);

    logic [CntW-1:0] words_q;

    // Registered committed-word count.
    always_ff @(posedge clk) begin
        if (reset) begin
            words_q <= '0;
        end else begin
            words_q <= words_q + CntW'(commit) - CntW'(pop);
        end
    end

    // Occupancy outputs.
    always_comb begin
        words_o = words_q;
        lanes_o = lane_q;
    end
`endif

endmodule

// File: tb/tb_fifo_pack_flush.sv
// Testbench for fifo_pack_flush: constant vector table, directed flush
// sequences and randomized traffic checked against a queue-based model.
module tb_fifo_pack_flush;

    localparam int         IN_W  = 4;
    localparam int         PACK  = 8;
    localparam int         DEPTH = 4;
    localparam logic [3:0] PAD   = 4'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid_i;
    logic        wr_ready_o;
    logic [3:0]  wr_data_i;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic [31:0] rd_data_o;
    logic [3:0]  rd_fill_o;
    logic        flush_req_i;
    logic        flush_done_o;
    logic        full_o;
    logic        empty_o;
`ifdef FIFO_PACK_OCC_EN
    logic [2:0]  words_o;
    logic [2:0]  lanes_o;
`endif

    fifo_pack_flush #(
        .IN_W        (IN_W),
        .PACK        (PACK),
        .DEPTH_WORDS (DEPTH),
        .PAD_VAL     (PAD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_data_i    (wr_data_i),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .rd_data_o    (rd_data_o),
        .rd_fill_o    (rd_fill_o),
        .flush_req_i  (flush_req_i),
        .flush_done_o (flush_done_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
`ifdef FIFO_PACK_OCC_EN
        ,
        .words_o      (words_o),
        .lanes_o      (lanes_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of committed words, list of held beats, flush phase
    // (0 idle, 1 sealing, 2 draining, 3 done).
    logic [31:0] m_data[$];
    int          m_fill[$];
    logic [3:0]  m_part[$];
    int          m_mode;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output bundle: {wr_ready, rd_valid, rd_data, rd_fill, full, empty, done}.
    function automatic logic [40:0] mk(input logic wr, input logic rv, input logic [31:0] d,
                                       input logic [3:0] f, input logic fu, input logic em,
                                       input logic dn);
        return {wr, rv, d, f, fu, em, dn};
    endfunction

    function automatic logic [40:0] dut_outs();
        return {wr_ready_o, rd_valid_o, rd_data_o, rd_fill_o, full_o, empty_o, flush_done_o};
    endfunction

    function automatic logic [40:0] model_outs();
        int          cnt   = m_data.size();
        int          lanes = m_part.size();
        logic        wr    = (m_mode == 0) && ((lanes != PACK - 1) || (cnt < DEPTH));
        logic [31:0] d     = (cnt > 0) ? m_data[0] : 32'h0;
        logic [3:0]  f     = (cnt > 0) ? 4'(m_fill[0]) : 4'h0;
        return mk(wr, cnt > 0, d, f, cnt == DEPTH, (cnt == 0) && (lanes == 0), m_mode == 3);
    endfunction

    task automatic push_word(input int fill);
        logic [31:0] w = '0;
        for (int k = 0; k < PACK; k++) begin
            w[k*IN_W +: IN_W] = (k < m_part.size()) ? m_part[k] : PAD;
        end
        m_data.push_back(w);
        m_fill.push_back(fill);
        m_part.delete();
    endtask

    task automatic model_step(input logic wv, input logic [3:0] wd, input logic rr,
                              input logic fr);
        int cnt   = m_data.size();
        int lanes = m_part.size();
        bit wready = (m_mode == 0) && ((lanes != PACK - 1) || (cnt < DEPTH));
        if ((cnt > 0) && rr) begin
            void'(m_data.pop_front());
            void'(m_fill.pop_front());
        end
        if (wv && wready) begin
            m_part.push_back(wd);
            if (m_part.size() == PACK) push_word(PACK);
        end
        case (m_mode)
            0: if (fr) m_mode = 1;
            1: begin
                if (lanes == 0) begin
                    m_mode = 2;
                end else if (cnt < DEPTH) begin
                    push_word(lanes);
                    m_mode = 2;
                end
            end
            2: if (cnt == 0) m_mode = 3;
            default: m_mode = 0;
        endcase
    endtask

    task automatic model_reset();
        m_data.delete();
        m_fill.delete();
        m_part.delete();
        m_mode = 0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        wr_valid_i  = 1'b0;
        wr_data_i   = 4'h0;
        rd_ready_i  = 1'b0;
        flush_req_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: apply inputs, compare against the model, advance both.
    task automatic cycle(input logic wv, input logic [3:0] wd, input logic rr, input logic fr,
                         input string tag, output logic [40:0] obs);
        wr_valid_i  = wv;
        wr_data_i   = wd;
        rd_ready_i  = rr;
        flush_req_i = fr;
        #1;
        obs = dut_outs();
        check(tag, obs, model_outs());
`ifdef FIFO_PACK_OCC_EN
        check({tag, "_words"}, words_o, m_data.size());
        check({tag, "_lanes"}, lanes_o, m_part.size());
`endif
        @(posedge clk);
        model_step(wv, wd, rr, fr);
        #1;
    endtask

    typedef struct {
        logic        wv;
        logic [3:0]  wd;
        logic        rr;
        logic        fr;
        logic [40:0] exp;
    } vec_t;

    vec_t        vecs[11];
    logic [40:0] obs;
    logic [3:0]  beats[96];
    logic [31:0] ew;
    logic [31:0] last_data;
    logic [3:0]  last_fill;
    logic [2:0]  done_seq;
    logic        rv_any;
    logic        done_seen;
    logic        wv;
    logic [3:0]  wd;
    logic        rr;
    int          sent;
    int          popped;
    int          npop;
    int          ndone;

    initial begin
        // Back-to-back beats 1..8, then read the packed word.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, 4'(i + 1), 1'b0, 1'b0,
                        mk(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, i == 0, 1'b0)};
        end
        vecs[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, mk(1'b1, 1'b1, 32'h87654321, 4'h8, 1'b0, 1'b0, 1'b0)};
        vecs[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, mk(1'b1, 1'b1, 32'h87654321, 4'h8, 1'b0, 1'b0, 1'b0)};
        vecs[10] = '{1'b0, 4'h0, 1'b0, 1'b0, mk(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0)};

        do_reset();
        check("reset_outs", dut_outs(), mk(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].fr, $sformatf("vec%0d_model", i), obs);
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end

        // Partial word 1,2,3 sealed by a flush.
        do_reset();
        for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, "part_wr", obs);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "part_req", obs);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, "part_seal", obs);
        check("part_seal_wready", obs[40], 1'b0);
        cycle(1'b0, 4'h0, 1'b1, 1'b0, "part_drain", obs);
        check("part_data", obs[38:7], 32'hCCCCC321);
        check("part_fill", obs[6:3], 4'h3);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 4'h0, 1'b0, 1'b0, "part_tail", obs);
            ndone += int'(obs[0]);
        end
        check("part_done_count", ndone, 1);
        check("part_wready_back", obs[40], 1'b1);

        // Full queue plus a 7-lane partial word: SEAL waits for a free slot.
        do_reset();
        for (int i = 0; i < 39; i++) cycle(1'b1, 4'(i + 1), 1'b0, 1'b0, "full_wr", obs);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, "full_chk", obs);
        check("full_flag", obs[2], 1'b1);
        check("full_wready", obs[40], 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "full_req", obs);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 1'b0, 1'b0, "full_hold", obs);
        cycle(1'b0, 4'h0, 1'b1, 1'b0, "full_pop", obs);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, "full_freed", obs);
        check("seal_slot_free", obs[2], 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, "full_sealed", obs);
        check("seal_committed", obs[2], 1'b1);
        npop = 0;
        done_seen = 1'b0;
        last_data = '0;
        last_fill = '0;
        for (int i = 0; i < 30 && !done_seen; i++) begin
            cycle(1'b0, 4'h0, 1'b1, 1'b0, "full_drain", obs);
            if (obs[39]) begin
                npop++;
                last_data = obs[38:7];
                last_fill = obs[6:3];
            end
            done_seen = obs[0];
        end
        check("seal_done_seen", done_seen, 1'b1);
        check("seal_npop", npop, 4);
        check("seal_last_fill", last_fill, 4'h7);
        check("seal_last_data", last_data, 32'hC7654321);

        // Flush on an empty FIFO: done exactly three cycles after the request.
        do_reset();
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "empty_req", obs);
        rv_any = obs[39];
        for (int j = 0; j < 3; j++) begin
            cycle(1'b0, 4'h0, 1'b0, 1'b0, "empty_flush", obs);
            done_seq[j] = obs[0];
            rv_any |= obs[39];
        end
        check("empty_done_seq", done_seq, 3'b100);
        check("empty_rvalid", rv_any, 1'b0);

        // Reset while draining two words aborts the flush.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0, "abort_wr", obs);
        cycle(1'b0, 4'h0, 1'b0, 1'b1, "abort_req", obs);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, "abort_seal", obs);
        check("abort_queued", obs[2:1], 2'b00);
        reset      = 1'b1;
        wr_valid_i = 1'b0;
        rd_ready_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("abort_reset_outs", dut_outs(), mk(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0));
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'h0, 1'b0, 1'b0, "abort_after", obs);
            ndone += int'(obs[0]);
        end
        check("abort_no_done", ndone, 0);

        // Stream 12 words with random handshakes; order checked across wraps.
        do_reset();
        for (int i = 0; i < 96; i++) beats[i] = 4'($urandom);
        sent = 0;
        popped = 0;
        for (int c = 0; c < 3000 && popped < 12; c++) begin
            wv = (sent < 96) && ($urandom_range(0, 3) != 0);
            wd = (sent < 96) ? beats[sent] : 4'h0;
            rr = 1'($urandom_range(0, 1));
            cycle(wv, wd, rr, 1'b0, "stream", obs);
            if (wv && obs[40]) sent++;
            if (obs[39] && rr) begin
                for (int k = 0; k < PACK; k++) ew[k*IN_W +: IN_W] = beats[popped*PACK + k];
                check($sformatf("stream_word%0d", popped), obs[38:7], ew);
                popped++;
            end
        end
        check("stream_count", popped, 12);

        // Random traffic with occasional flush requests.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 15) == 0), "random", obs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_pack_flush.md
# fifo_pack_flush

Parametrised narrow-to-wide packing FIFO with a request/done flush handshake, the next generation of our nibble-packing flush FIFO. Narrow write beats are packed lane-by-lane into wide words that are stored in a word-deep queue and read through a valid/ready port. A flush seals any partial word by padding its unfilled lanes with a constant, then drains the queue and reports completion. It sits between narrow producers, such as trace or debug collectors, and a wide consumer bus.

## Interface
- IN_W, 4: width of one write beat (lane).
- PACK, 8: lanes per wide word; power of 2, ≥2.
- DEPTH_WORDS, 4: committed-word capacity; power of 2, ≥2.
- PAD_VAL, 4'hC: IN_W-bit value placed in unfilled lanes of a sealed word.
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- wr_valid_i  in  1  write beat present.
- wr_ready_o  out  1  write beat can be accepted.
- wr_data_i  in  IN_W  write beat.
- rd_valid_o  out  1  head word available.
- rd_ready_i  in  1  consumer pops head word.
- rd_data_o  out  IN_W*PACK  head word; lane k at bits [k*IN_W +: IN_W].
- rd_fill_o  out  $clog2(PACK+1)  number of real (non-pad) lanes in the head word.
- flush_req_i  in  1  flush request; sampled only in IDLE.
- flush_done_o  out  1  one-cycle completion pulse.
- full_o  out  1  committed count == DEPTH_WORDS.
- empty_o  out  1  committed count == 0 and no partial lanes held.

## Operation
- Assembly register: PACK lanes plus lane index `lane` (0..PACK-1). An accepted beat (wr_valid_i & wr_ready_o) is written into lane `lane`, and `lane` increments.
- On the accepted beat at lane PACK-1, the assembled word is committed to the tail with fill=PACK, and `lane` returns to 0.
- Storage: DEPTH_WORDS entries of {data, fill}, with wr/rd pointers carrying one extra wrap bit. Count is the difference between the pointers.
- Pop: when rd_valid_o & rd_ready_i, the read pointer advances. rd_data_o and rd_fill_o are driven combinationally from the head entry; when the queue is empty they are 0.
- wr_ready_o = (state==IDLE) & (lane!=PACK-1 | count<DEPTH_WORDS). It does not depend on rd_ready_i.
- Flush FSM states:
  - IDLE: flush_req_i=1 moves to SEAL. A write accepted in the same cycle is included in the flush.
  - SEAL: if lane==0, go to DRAIN. Otherwise, if count<DEPTH_WORDS, commit the word with lanes ≥`lane` set to PAD_VAL and fill=`lane`, clear `lane`, and go to DRAIN. If full, stay in SEAL; a pop in the same cycle does not free the slot until the next cycle.
  - DRAIN: when count==0, go to DONE. Pops continue normally.
  - DONE: flush_done_o=1 for this cycle only, then go to IDLE.
- wr_ready_o=0 in SEAL, DRAIN and DONE. flush_req_i is ignored outside IDLE.
- Reset (any state) clears pointers, `lane`, FSM→IDLE and outputs. Stored data need not be cleared. Reset mid-flush aborts the flush without a done pulse.

## Timing
- Reset values: wr_ready_o=1, rd_valid_o=0, rd_data_o=0, rd_fill_o=0, flush_done_o=0, full_o=0, empty_o=1.
- Write→read latency: the word commits on the edge of its PACK-th accepted beat, and rd_valid_o is high in the following cycle.
- Pop and commit in the same cycle are both honoured; the count is unchanged.
- Flush on an empty FIFO with a request in cycle t: SEAL in t+1, DRAIN in t+2, DONE (flush_done_o=1) in t+3.
- A partial word sealed in SEAL at cycle s is visible on rd_valid_o at s+1.
- Pointer wrap: entries are read strictly in commit order across any number of wraps. full_o and empty_o are exact at wrap.

## Configuration
- FIFO_PACK_OCC_EN defined: adds an output port words_o ($clog2(DEPTH_WORDS+1) bits, registered count of committed words, reset 0) and an output lanes_o ($clog2(PACK) bits, equal to `lane`).
- FIFO_PACK_OCC_EN undefined: neither port exists. All other behaviour is identical.

## Test plan
Defaults: IN_W=4, PACK=8, DEPTH_WORDS=4, PAD_VAL=4'hC.
- Reset, then write beats 1..8 back-to-back → rd_valid_o=1 the next cycle, rd_data_o=32'h87654321, rd_fill_o=8, empty_o=0.
- Write 1,2,3, then pulse flush_req_i → wr_ready_o=0; rd_data_o=32'hCCCCC321 with rd_fill_o=3; after the pop, flush_done_o pulses once and wr_ready_o returns to 1.
- Commit 4 words, then write 7 beats → full_o=1, wr_ready_o=0. Flush → FSM holds in SEAL until a pop; the padded word (fill 7) is committed the cycle after the pop.
- Flush on an empty FIFO → flush_done_o=1 exactly 3 cycles after the request; rd_valid_o stays 0 throughout.
- Assert reset while in DRAIN with 2 words queued → all outputs take their reset values the next cycle, and no flush_done_o pulse appears.
- Stream 12 words with random rd_ready_i → 12 words are read in order across pointer wrap, with no loss or duplication and full_o/empty_o consistent with count.
